// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time controller: BCD MM:SS keypad entry, per-second countdown,
// start/pause/cancel sequencing and door interlock.
module cook_timer_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_open,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done,
    output logic       digit_err,
    output logic [1:0] state
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t        state_reg, state_next;
    logic [15:0]   time_reg, time_next;
    logic [CW-1:0] tick_reg, tick_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;

    // One-second decrement of {m1,m0,s1,s0}. A nibble borrows exactly when every
    // nibble below it is zero, so each borrow is derived directly, without a ripple chain.
    logic [15:0] time_dec;
    logic [3:0]  borrow;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            localparam logic [3:0] WRAP = (gi == 1) ? 4'd5 : 4'd9;
            logic [3:0] nib;
            assign nib        = time_reg[4*gi +: 4];
            assign borrow[gi] = ((time_reg << (16 - 4*gi)) == 16'd0);
            assign time_dec[4*gi +: 4] = !borrow[gi]  ? nib :
                                         (nib == 4'd0) ? WRAP : nib - 4'd1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            time_reg  <= 16'd0;
            tick_reg  <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            time_reg  <= time_next;
            tick_reg  <= tick_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        time_next  = time_reg;
        tick_next  = tick_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        if (clear) begin
            state_next = S_IDLE;
            time_next  = 16'd0;
            tick_next  = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (stop) begin
                        state_next = S_IDLE;
                    end else if (start) begin
                        // The door only blocks the start itself; the key press is still consumed.
                        if (!door_open) begin
                            state_next = S_RUN;
                            tick_next  = '0;
                            if (time_reg == 16'd0)
                                time_next = 16'h0030;
                        end
                    end else if (digit_valid) begin
                        if (digit <= 4'd9)
                            time_next = {time_reg[11:0], digit};
                        else
                            err_next = 1'b1;
                    end
                end
                S_RUN: begin
                    if (door_open || stop) begin
                        state_next = S_PAUSE;
                    end else if (tick_reg == TICK_LAST) begin
                        tick_next = '0;
                        time_next = time_dec;
                        if (time_dec == 16'd0) begin
                            state_next = S_DONE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        state_next = S_IDLE;
                        time_next  = 16'd0;
                        tick_next  = '0;
                    end else if (start && !door_open) begin
                        state_next = S_RUN;
                        tick_next  = '0;
                    end
                end
                S_DONE: begin
                    if (stop || start || door_open) begin
                        state_next = S_IDLE;
                        time_next  = 16'd0;
                        tick_next  = '0;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        state     = state_reg;
        running   = (state_reg == S_RUN);
        done      = done_reg;
        digit_err = err_reg;
        min_bcd   = time_reg[15:8];
        sec_bcd   = time_reg[7:0];
    end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Self-checking bench for cook_timer_ctrl: vector table with a scoreboard queue,
// plus a hand-written countdown-to-DONE sequence.
module tb_cook_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       door_open = 1'b0;
    logic [7:0] min_bcd, sec_bcd;
    logic       running, done, digit_err;
    logic [1:0] state;

    cook_timer_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
        .start(start), .stop(stop), .clear(clear), .door_open(door_open),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .done(done),
        .digit_err(digit_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_RST, OP_DIGIT, OP_START, OP_STOP, OP_CLEAR, OP_DOOR, OP_WAIT, OP_COMBO} op_t;

    typedef struct {
        op_t         op;
        int          arg;
        logic [20:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [20:0] v;
    } exp_t;

    localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DN = 2'b11;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input op_t op, input int arg, input logic [1:0] st,
                       input logic [15:0] t, input logic run, input logic dn, input logic er);
        vec_t v;
        v.op  = op;
        v.arg = arg;
        v.exp = {st, t, run, dn, er};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        case (v.op)
            OP_RST:   begin rst = 1'b1; repeat (v.arg) @(posedge clk); #1; rst = 1'b0; end
            OP_DIGIT: begin digit = 4'(v.arg); digit_valid = 1'b1; edge1(); digit_valid = 1'b0; end
            OP_START: begin start = 1'b1; edge1(); start = 1'b0; end
            OP_STOP:  begin stop = 1'b1; edge1(); stop = 1'b0; end
            OP_CLEAR: begin clear = 1'b1; edge1(); clear = 1'b0; end
            OP_DOOR:  begin door_open = v.arg[0]; edge1(); end
            OP_WAIT:  begin repeat (v.arg) @(posedge clk); #1; end
            OP_COMBO: begin
                clear = 1'b1; start = 1'b1; digit_valid = 1'b1; digit = 4'd7;
                edge1();
                clear = 1'b0; start = 1'b0; digit_valid = 1'b0;
            end
            default: ;
        endcase
    endtask

    initial begin
        exp_t e;
        int   done_cnt;
        int   done_at;

        // Reset, digit entry and illegal digit
        add(OP_RST,   2,  IDLE,  16'h0000, 0, 0, 0);
        add(OP_DIGIT, 1,  IDLE,  16'h0001, 0, 0, 0);
        add(OP_DIGIT, 2,  IDLE,  16'h0012, 0, 0, 0);
        add(OP_DIGIT, 3,  IDLE,  16'h0123, 0, 0, 0);
        add(OP_DIGIT, 4,  IDLE,  16'h1234, 0, 0, 0);
        add(OP_DIGIT, 10, IDLE,  16'h1234, 0, 0, 1);
        add(OP_WAIT,  1,  IDLE,  16'h1234, 0, 0, 0);
        add(OP_DIGIT, 5,  IDLE,  16'h2345, 0, 0, 0);
        add(OP_CLEAR, 0,  IDLE,  16'h0000, 0, 0, 0);
        // Countdown with borrow from minutes
        add(OP_DIGIT, 0,  IDLE,  16'h0000, 0, 0, 0);
        add(OP_DIGIT, 1,  IDLE,  16'h0001, 0, 0, 0);
        add(OP_DIGIT, 0,  IDLE,  16'h0010, 0, 0, 0);
        add(OP_DIGIT, 0,  IDLE,  16'h0100, 0, 0, 0);
        add(OP_START, 0,  RUN,   16'h0100, 1, 0, 0);
        add(OP_WAIT,  3,  RUN,   16'h0100, 1, 0, 0);
        add(OP_WAIT,  1,  RUN,   16'h0059, 1, 0, 0);
        add(OP_WAIT,  4,  RUN,   16'h0058, 1, 0, 0);
        add(OP_START, 0,  RUN,   16'h0058, 1, 0, 0);
        // Quick start
        add(OP_CLEAR, 0,  IDLE,  16'h0000, 0, 0, 0);
        add(OP_START, 0,  RUN,   16'h0030, 1, 0, 0);
        // Completion
        add(OP_CLEAR, 0,  IDLE,  16'h0000, 0, 0, 0);
        add(OP_DIGIT, 0,  IDLE,  16'h0000, 0, 0, 0);
        add(OP_DIGIT, 2,  IDLE,  16'h0002, 0, 0, 0);
        add(OP_START, 0,  RUN,   16'h0002, 1, 0, 0);
        add(OP_WAIT,  4,  RUN,   16'h0001, 1, 0, 0);
        add(OP_WAIT,  3,  RUN,   16'h0001, 1, 0, 0);
        add(OP_WAIT,  1,  DN,    16'h0000, 0, 1, 0);
        add(OP_WAIT,  1,  DN,    16'h0000, 0, 0, 0);
        add(OP_STOP,  0,  IDLE,  16'h0000, 0, 0, 0);
        // Door interlock
        add(OP_DIGIT, 5,  IDLE,  16'h0005, 0, 0, 0);
        add(OP_START, 0,  RUN,   16'h0005, 1, 0, 0);
        add(OP_WAIT,  1,  RUN,   16'h0005, 1, 0, 0);
        add(OP_DOOR,  1,  PAUSE, 16'h0005, 0, 0, 0);
        add(OP_WAIT,  20, PAUSE, 16'h0005, 0, 0, 0);
        add(OP_START, 0,  PAUSE, 16'h0005, 0, 0, 0);
        add(OP_DOOR,  0,  PAUSE, 16'h0005, 0, 0, 0);
        add(OP_START, 0,  RUN,   16'h0005, 1, 0, 0);
        add(OP_WAIT,  3,  RUN,   16'h0005, 1, 0, 0);
        add(OP_WAIT,  1,  RUN,   16'h0004, 1, 0, 0);
        // Stop pauses, second stop cancels
        add(OP_STOP,  0,  PAUSE, 16'h0004, 0, 0, 0);
        add(OP_STOP,  0,  IDLE,  16'h0000, 0, 0, 0);
        // Borrow all the way into tens of minutes
        add(OP_DIGIT, 1,  IDLE,  16'h0001, 0, 0, 0);
        add(OP_DIGIT, 0,  IDLE,  16'h0010, 0, 0, 0);
        add(OP_DIGIT, 0,  IDLE,  16'h0100, 0, 0, 0);
        add(OP_DIGIT, 0,  IDLE,  16'h1000, 0, 0, 0);
        add(OP_START, 0,  RUN,   16'h1000, 1, 0, 0);
        add(OP_WAIT,  4,  RUN,   16'h0959, 1, 0, 0);
        // Simultaneous clear/start/digit in RUN, then mid-run reset
        add(OP_COMBO, 0,  IDLE,  16'h0000, 0, 0, 0);
        add(OP_DIGIT, 9,  IDLE,  16'h0009, 0, 0, 0);
        add(OP_START, 0,  RUN,   16'h0009, 1, 0, 0);
        add(OP_WAIT,  2,  RUN,   16'h0009, 1, 0, 0);
        add(OP_RST,   1,  IDLE,  16'h0000, 0, 0, 0);
        add(OP_WAIT,  4,  IDLE,  16'h0000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            e.name = $sformatf("vec%0d_op%0d", i, int'(vecs[i].op));
            e.v    = vecs[i].exp;
            sb.push_back(e);
            apply(vecs[i]);
            e = sb.pop_front();
            check(e.name, 32'({state, min_bcd, sec_bcd, running, done, digit_err}), 32'(e.v));
        end

        // Hand-written: 00:01 countdown, done must pulse once, TICK_DIV cycles after start
        clear = 1'b1; edge1(); clear = 1'b0;
        digit = 4'd1; digit_valid = 1'b1; edge1(); digit_valid = 1'b0;
        start = 1'b1; edge1(); start = 1'b0;
        done_cnt = 0;
        done_at  = -1;
        for (int c = 1; c <= 12; c++) begin
            edge1();
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        check("done_pulse_count", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_at), 32'd4);
        check("done_state_hold", 32'({state, min_bcd, sec_bcd}), 32'({DN, 16'h0000}));
        start = 1'b1; edge1(); start = 1'b0;
        check("start_in_done_to_idle", 32'({state, running}), 32'({IDLE, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
